// File: rtl/sm83_bus_responder_if.sv
// CPU-side and external-side bus signals of the SM83 memory responder.
// The master modport is the CPU core plus external memory; the slave modport is the responder.
interface sm83_bus_responder_if;
    logic [15:0] cpu_addr;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic [15:0] ext_addr;
    logic        ext_rd;
    logic        ext_wr;
    logic [7:0]  ext_wdata;
    logic [7:0]  ext_rdata;
    logic [4:0]  irq_req;
    logic        int_pending;
    logic        dma_active;

    modport master (
        output cpu_addr, cpu_rd, cpu_wr, cpu_wdata, ext_rdata, irq_req,
        input  cpu_rdata, ext_addr, ext_rd, ext_wr, ext_wdata, int_pending, dma_active
    );

    modport slave (
        input  cpu_addr, cpu_rd, cpu_wr, cpu_wdata, ext_rdata, irq_req,
        output cpu_rdata, ext_addr, ext_rd, ext_wr, ext_wdata, int_pending, dma_active
    );
endinterface

// File: rtl/sm83_bus_responder.sv
// Memory-side end of the SM83 bus: local HRAM/IF/IE/FF46, external forwarding, OAM DMA.
// Define SM83_BUS_OAM_DMA_EN to build the OAM DMA engine; otherwise FF46 is a plain R/W byte.
module sm83_bus_responder #(
    parameter int unsigned DMA_LEN  = 160,
    parameter logic [15:0] OAM_BASE = 16'hFE00,
    parameter logic [7:0]  IF_RESET = 8'hE1
) (
    input logic clk,
    input logic rst_n,
    sm83_bus_responder_if.slave bus
);

    localparam logic [15:0] ADDR_IF    = 16'hFF0F;
    localparam logic [15:0] ADDR_IE    = 16'hFFFF;
    localparam logic [15:0] ADDR_DMA   = 16'hFF46;
    localparam int unsigned HRAM_DEPTH = 127;

    logic       sel_hram, sel_if, sel_ie, sel_dma, sel_local;
    logic       rd_req, wr_req;
    logic [7:0] hram [HRAM_DEPTH];
    logic [4:0] if_q;
    logic [7:0] ie_q;
    logic [7:0] dma_reg_q;
    logic [7:0] rdata_q;
    logic       rd_ext_q;
    logic [7:0] local_rdata;
    logic       dma_busy;

    // Address decode; a simultaneous read+write is treated as a write only
    assign sel_hram  = (bus.cpu_addr[15:7] == 9'h1FF) && (bus.cpu_addr != ADDR_IE);
    assign sel_if    = (bus.cpu_addr == ADDR_IF);
    assign sel_ie    = (bus.cpu_addr == ADDR_IE);
    assign sel_dma   = (bus.cpu_addr == ADDR_DMA);
    assign sel_local = sel_hram | sel_if | sel_ie | sel_dma;
    assign wr_req    = bus.cpu_wr;
    assign rd_req    = bus.cpu_rd & ~bus.cpu_wr;

    always_ff @(posedge clk) begin
        if (wr_req && sel_hram) begin
            hram[bus.cpu_addr[6:0]] <= bus.cpu_wdata;
        end
    end

    always_comb begin
        local_rdata = 8'hFF;
        if (sel_hram) begin
            local_rdata = hram[bus.cpu_addr[6:0]];
        end else if (sel_if) begin
            local_rdata = {3'b111, if_q};
        end else if (sel_ie) begin
            local_rdata = ie_q;
        end else if (sel_dma) begin
            local_rdata = dma_reg_q;
        end
    end

    // Local registers; IF merges new requests so a clearing write never drops one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_q      <= IF_RESET[4:0];
            ie_q      <= 8'h00;
            dma_reg_q <= 8'h00;
        end else begin
            if_q <= ((wr_req && sel_if) ? bus.cpu_wdata[4:0] : if_q) | bus.irq_req;
            if (wr_req && sel_ie) begin
                ie_q <= bus.cpu_wdata;
            end
            if (wr_req && sel_dma) begin
                dma_reg_q <= bus.cpu_wdata;
            end
        end
    end

    // Read return: local data is registered, external data arrives the next cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q  <= 8'hFF;
            rd_ext_q <= 1'b0;
        end else begin
            if (rd_ext_q) begin
                rdata_q <= bus.ext_rdata;
            end
            rd_ext_q <= 1'b0;
            if (rd_req) begin
                if (sel_local) begin
                    rdata_q <= local_rdata;
                end else if (dma_busy) begin
                    rdata_q <= 8'hFF;
                end else begin
                    rd_ext_q <= 1'b1;
                end
            end
        end
    end

    assign bus.cpu_rdata   = rd_ext_q ? bus.ext_rdata : rdata_q;
    assign bus.int_pending = |(ie_q[4:0] & if_q);
    assign bus.dma_active  = dma_busy;

`ifdef SM83_BUS_OAM_DMA_EN
    localparam int unsigned IDX_W = (DMA_LEN > 1) ? $clog2(DMA_LEN) : 1;

    typedef enum logic [1:0] {
        DMA_IDLE,
        DMA_RD,
        DMA_WR
    } dma_state_e;

    dma_state_e       state_q;
    logic [IDX_W-1:0] idx_q;

    // An FF46 write (re)starts the copy from index 0, whatever the current state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DMA_IDLE;
            idx_q   <= '0;
        end else if (wr_req && sel_dma) begin
            state_q <= DMA_RD;
            idx_q   <= '0;
        end else begin
            case (state_q)
                DMA_RD: state_q <= DMA_WR;
                DMA_WR: begin
                    if (idx_q == IDX_W'(DMA_LEN - 1)) begin
                        state_q <= DMA_IDLE;
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                        state_q <= DMA_RD;
                    end
                end
                default: state_q <= DMA_IDLE;
            endcase
        end
    end

    assign dma_busy = (state_q != DMA_IDLE);

    always_comb begin
        bus.ext_addr  = bus.cpu_addr;
        bus.ext_wdata = bus.cpu_wdata;
        bus.ext_rd    = rd_req & ~sel_local;
        bus.ext_wr    = wr_req & ~sel_local;
        case (state_q)
            DMA_RD: begin
                bus.ext_addr  = {dma_reg_q, 8'h00} + 16'(idx_q);
                bus.ext_wdata = 8'h00;
                bus.ext_rd    = 1'b1;
                bus.ext_wr    = 1'b0;
            end
            DMA_WR: begin
                bus.ext_addr  = OAM_BASE + 16'(idx_q);
                bus.ext_wdata = bus.ext_rdata;
                bus.ext_rd    = 1'b0;
                bus.ext_wr    = 1'b1;
            end
            default: ;
        endcase
    end
`else
    logic unused_cfg;

    assign unused_cfg = ^{OAM_BASE, 32'(DMA_LEN)};
    assign dma_busy   = 1'b0;

    always_comb begin
        bus.ext_addr  = bus.cpu_addr;
        bus.ext_wdata = bus.cpu_wdata;
        bus.ext_rd    = rd_req & ~sel_local;
        bus.ext_wr    = wr_req & ~sel_local;
    end
`endif

endmodule
